rf_op_sequencer: RTL and testbench
==================================

// Module: rf_op_sequencer
// PURPOSE
//   Upstream controller for the 8x16 register file and its datapath (A/B regs, shifter, ALU, C/status regs).
//   Accepts one register-level operation per start pulse and sequences readnum/writenum/write and the load/select strobes.
//   Multi-cycle Moore FSM; sits between switch/instruction input and the datapath.
// PARAMETERS
//   REGW   3   register-number width (8 registers)
//   OPW    3   opcode width
// PORTS
//   clk       in   1     rising-edge clock, sole clock
//   reset     in   1     synchronous, active-high
//   start     in   1     request; sampled only when ready=1
//   opcode    in   OPW   000 MOVI, 001 MOVR, 010 ADD, 011 CMP, 100 AND, 101 MVN, 11x illegal
//   rd,rn,rm  in   REGW  destination / first / second source register numbers
//   shift_in  in   2     shifter control applied to Rm operand
//   readnum   out  REGW  regfile read select
//   writenum  out  REGW  regfile write select
//   write     out  1     regfile write enable
//   loada,loadb,loadc,loads  out 1 each  datapath register load strobes
//   asel,bsel,vsel  out  1 each  A-zero select, B-imm select, writeback-imm select
//   shift     out  2     shifter control (latched shift_in)
//   alu_op    out  2     00 ADD, 01 SUB, 10 AND, 11 MVN
//   ready     out  1     high only in WAIT
//   done      out  1     1-cycle pulse in final state of an op
//   err       out  1     1-cycle pulse when an illegal opcode is accepted
// BEHAVIOUR
//   - Clock and reset are fixed: one clock (clk); reset is synchronous and active-high.
//   - Reset: state<=WAIT, latched fields<=0. After the reset edge: ready=1, all other outputs 0.
//   - Strobes gated by ~reset: reset asserted in any state suppresses write/load* that cycle (aborted op writes nothing).
//   - Accept: ready&start at edge latches opcode,rd,rn,rm,shift_in; start while ready=0 ignored, not queued.
//   - Moore outputs decoded from state + latched fields; every output is 0 unless listed for the state.
//   - States / outputs / next:
//       WAIT  : ready=1; -> per opcode (MOVI->WIMM, MOVR->LDB, ADD/CMP/AND->LDA, MVN->LDB, illegal->ERR)
//       LDA   : readnum=rn, loada=1 -> LDB
//       LDB   : readnum=rm, loadb=1 -> EXEC
//       EXEC  : loadc=1, shift=latched, alu_op per opcode (MOVR ADD+asel=1, CMP SUB+loads=1, no loadc for CMP);
//               CMP: done=1 -> WAIT; else -> WREG
//       WREG  : writenum=rd, write=1, vsel=0, done=1 -> WAIT
//       WIMM  : writenum=rd, write=1, vsel=1, done=1 -> WAIT
//       ERR   : err=1 -> WAIT (no strobes)
//   - Latency start-edge->done cycle: MOVI 1, ERR 1, CMP 3, MOVR/MVN 3, ADD/AND 4; back-to-back: next start accepted
//     the cycle after done (ready=1 in WAIT).
//   - readnum/writenum are 0 when not driven by the state; rd==rn==rm permitted (sequencing guarantees reads precede write).
//   - Unused state encodings -> WAIT next cycle, outputs 0.
// STRUCTURE
//   - Shared package/header: opcode localparams, ALU op codes, state encoding (one-hot or 3-bit, consistent).
//   - Sub-module: seq_instr_reg, load-enabled register (load=ready&start) holding {opcode,rd,rn,rm,shift}.
//   - Top: state register, next-state case, output decode case.
// TESTING
//   - Reset: reset=1 two cycles -> ready=1, write=0, all loads 0, readnum=writenum=0.
//   - MOVI rd=3: start -> next cycle writenum=3, write=1, vsel=1, done=1; following cycle ready=1.
//   - ADD rd=2,rn=0,rm=1,shift=01: readnum 0 (loada), 1 (loadb), EXEC alu_op=00 shift=01 loadc, WREG writenum=2 write=1 done.
//   - CMP rn=5,rm=5: LDA,LDB, EXEC alu_op=01 loads=1 loadc=0 done=1; write never asserted.
//   - opcode=111: err=1 one cycle, write/load* stay 0; start asserted during ADD's LDB ignored.
//   - Reset asserted during WREG of AND rd=7: write=0 that cycle, R7 unchanged, next cycle ready=1.

Source files
------------

// File: rtl/rf_op_sequencer_pkg.sv
// Shared constants for the register-file operation sequencer: opcodes, ALU codes,
// state encoding and the latched instruction record.
package rf_op_sequencer_pkg;

  localparam int REGW = 3;
  localparam int OPW  = 3;

  localparam logic [OPW-1:0] OP_MOVI = 3'b000;
  localparam logic [OPW-1:0] OP_MOVR = 3'b001;
  localparam logic [OPW-1:0] OP_ADD  = 3'b010;
  localparam logic [OPW-1:0] OP_CMP  = 3'b011;
  localparam logic [OPW-1:0] OP_AND  = 3'b100;
  localparam logic [OPW-1:0] OP_MVN  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_LDA  = 3'd1;
  localparam logic [2:0] S_LDB  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WREG = 3'd4;
  localparam logic [2:0] S_WIMM = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rn;
    logic [REGW-1:0] rm;
    logic [1:0]      shift;
  } instr_t;

  // First state after WAIT for an accepted opcode.
  function automatic logic [2:0] first_state(input logic [OPW-1:0] op);
    case (op)
      OP_MOVI:                first_state = S_WIMM;
      OP_MOVR, OP_MVN:        first_state = S_LDB;
      OP_ADD, OP_CMP, OP_AND: first_state = S_LDA;
      default:                first_state = S_ERR;
    endcase
  endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Request and datapath-control bundle of the sequencer.
// Handshake: an op is accepted on a rising edge where ready=1 and start=1; start while
// ready=0 is dropped, never queued; done/err pulse for one cycle when the op retires.
interface rf_op_sequencer_if;
  import rf_op_sequencer_pkg::*;

  logic            start;
  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] rd;
  logic [REGW-1:0] rn;
  logic [REGW-1:0] rm;
  logic [1:0]      shift_in;

  logic [REGW-1:0] readnum;
  logic [REGW-1:0] writenum;
  logic            write;
  logic            loada;
  logic            loadb;
  logic            loadc;
  logic            loads;
  logic            asel;
  logic            bsel;
  logic            vsel;
  logic [1:0]      shift;
  logic [1:0]      alu_op;
  logic            ready;
  logic            done;
  logic            err;

  modport master (
    output start, opcode, rd, rn, rm, shift_in,
    input  readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, alu_op, ready, done, err
  );

  modport slave (
    input  start, opcode, rd, rn, rm, shift_in,
    output readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, alu_op, ready, done, err
  );
endinterface

// File: rtl/rf_op_sequencer_instr_reg.sv
// Load-enabled holding register for the accepted instruction fields.
module seq_instr_reg
  import rf_op_sequencer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  instr_t d,
  output instr_t q
);

  instr_t q_q;
  instr_t q_d;

  always_comb begin
    q_d = q_q;
    if (load) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rf_op_sequencer.sv
// Moore FSM that turns one register-level operation into the read/load/execute/write
// strobe sequence for the register file and datapath.
module rf_op_sequencer
  import rf_op_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  rf_op_sequencer_if.slave   bus,
  output logic [2:0]         dbg_state
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       accept;
  instr_t     instr_in;
  instr_t     instr;

  logic write_raw, loada_raw, loadb_raw, loadc_raw, loads_raw;

  assign accept   = (state_q == S_WAIT) && bus.start;
  assign instr_in = '{opcode: bus.opcode, rd: bus.rd, rn: bus.rn, rm: bus.rm,
                      shift: bus.shift_in};

  seq_instr_reg u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .d     (instr_in),
    .q     (instr)
  );

  always_comb begin
    state_d = S_WAIT;
    case (state_q)
      S_WAIT:  state_d = accept ? first_state(bus.opcode) : S_WAIT;
      S_LDA:   state_d = S_LDB;
      S_LDB:   state_d = S_EXEC;
      S_EXEC:  state_d = (instr.opcode == OP_CMP) ? S_WAIT : S_WREG;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.vsel     = 1'b0;
    bus.shift    = 2'b00;
    bus.alu_op   = ALU_ADD;
    write_raw    = 1'b0;
    loada_raw    = 1'b0;
    loadb_raw    = 1'b0;
    loadc_raw    = 1'b0;
    loads_raw    = 1'b0;
    case (state_q)
      S_WAIT: bus.ready = 1'b1;
      S_LDA: begin
        bus.readnum = instr.rn;
        loada_raw   = 1'b1;
      end
      S_LDB: begin
        bus.readnum = instr.rm;
        loadb_raw   = 1'b1;
      end
      S_EXEC: begin
        bus.shift = instr.shift;
        loadc_raw = 1'b1;
        case (instr.opcode)
          OP_MOVR: bus.asel = 1'b1;
          OP_CMP: begin
            bus.alu_op = ALU_SUB;
            loads_raw  = 1'b1;
            loadc_raw  = 1'b0;
            bus.done   = 1'b1;
          end
          OP_AND:  bus.alu_op = ALU_AND;
          OP_MVN:  bus.alu_op = ALU_MVN;
          default: bus.alu_op = ALU_ADD;
        endcase
      end
      S_WREG, S_WIMM: begin
        bus.writenum = instr.rd;
        write_raw    = 1'b1;
        bus.vsel     = (state_q == S_WIMM);
        bus.done     = 1'b1;
      end
      S_ERR:   bus.err = 1'b1;
      default: ;
    endcase
  end

  // Reset arriving mid-operation must leave the register file and datapath untouched.
  assign bus.write = write_raw & ~reset;
  assign bus.loada = loada_raw & ~reset;
  assign bus.loadb = loadb_raw & ~reset;
  assign bus.loadc = loadc_raw & ~reset;
  assign bus.loads = loads_raw & ~reset;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed-vector bench for rf_op_sequencer with hand-computed expected outputs.
module tb_rf_op_sequencer;
  import rf_op_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         vectors;
  int         miscompares;

  rf_op_sequencer_if bus ();

  rf_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flag order: ready done err write loada loadb loadc loads asel bsel vsel
  logic [20:0] obs;
  assign obs = {bus.ready, bus.done, bus.err, bus.write, bus.loada, bus.loadb,
                bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel,
                bus.shift, bus.alu_op, bus.readnum, bus.writenum};

  function automatic logic [20:0] ev(input logic [10:0] f, input logic [1:0] sh,
                                     input logic [1:0] al, input logic [2:0] rdn,
                                     input logic [2:0] wrn);
    ev = {f, sh, al, rdn, wrn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [20:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] exp);
    vectors++;
    assert (dbg_state === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] n,
                       input logic [2:0] m, input logic [1:0] sh);
    bus.start    = 1'b1;
    bus.opcode   = op;
    bus.rd       = d;
    bus.rn       = n;
    bus.rm       = m;
    bus.shift_in = sh;
  endtask

  localparam logic [10:0] F_IDLE = 11'b10000000000;
  localparam logic [10:0] F_LDA  = 11'b00001000000;
  localparam logic [10:0] F_LDB  = 11'b00000100000;
  localparam logic [10:0] F_EXC  = 11'b00000010000;
  localparam logic [10:0] F_EXR  = 11'b00000010100;
  localparam logic [10:0] F_CMP  = 11'b01000001000;
  localparam logic [10:0] F_WREG = 11'b01010000000;
  localparam logic [10:0] F_WIMM = 11'b01010000001;
  localparam logic [10:0] F_ERR  = 11'b00100000000;
  localparam logic [10:0] F_DONE = 11'b01000000000;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.opcode  = 3'b000;
    bus.rd      = 3'd0;
    bus.rn      = 3'd0;
    bus.rm      = 3'd0;
    bus.shift_in = 2'b00;

    step(); step();
    chk("reset_outputs", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));
    chk_state("reset_state", S_WAIT);
    reset = 1'b0;
    step();
    chk("idle_after_reset", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // MOVI rd=3
    issue(OP_MOVI, 3'd3, 3'd0, 3'd0, 2'b00);
    step(); bus.start = 1'b0;
    chk("movi_wimm", ev(F_WIMM, 2'b00, 2'b00, 3'd0, 3'd3));
    step();
    chk("movi_back_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // ADD rd=2, rn=0, rm=1, shift=01
    issue(OP_ADD, 3'd2, 3'd0, 3'd1, 2'b01);
    step(); bus.start = 1'b0;
    chk("add_lda", ev(F_LDA, 2'b00, 2'b00, 3'd0, 3'd0));
    step(); chk("add_ldb", ev(F_LDB, 2'b00, 2'b00, 3'd1, 3'd0));
    step(); chk("add_exec", ev(F_EXC, 2'b01, ALU_ADD, 3'd0, 3'd0));
    step(); chk("add_wreg", ev(F_WREG, 2'b00, 2'b00, 3'd0, 3'd2));
    step(); chk("add_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // CMP rn=5, rm=5, shift=10 (rd=6 must never be written)
    issue(OP_CMP, 3'd6, 3'd5, 3'd5, 2'b10);
    step(); bus.start = 1'b0;
    chk("cmp_lda", ev(F_LDA, 2'b00, 2'b00, 3'd5, 3'd0));
    step(); chk("cmp_ldb", ev(F_LDB, 2'b00, 2'b00, 3'd5, 3'd0));
    step(); chk("cmp_exec", ev(F_CMP, 2'b10, ALU_SUB, 3'd0, 3'd0));
    step(); chk("cmp_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // illegal opcode 111
    issue(3'b111, 3'd1, 3'd2, 3'd3, 2'b11);
    step(); bus.start = 1'b0;
    chk("illegal_err", ev(F_ERR, 2'b00, 2'b00, 3'd0, 3'd0));
    step(); chk("illegal_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // ADD rd=4, rn=1, rm=2 with a stray illegal start held while busy
    issue(OP_ADD, 3'd4, 3'd1, 3'd2, 2'b00);
    step();
    chk("add2_lda", ev(F_LDA, 2'b00, 2'b00, 3'd1, 3'd0));
    bus.opcode = 3'b111;
    step(); chk("add2_ldb_ignore_start", ev(F_LDB, 2'b00, 2'b00, 3'd2, 3'd0));
    step(); chk("add2_exec_ignore_start", ev(F_EXC, 2'b00, ALU_ADD, 3'd0, 3'd0));
    bus.start = 1'b0;
    step(); chk("add2_wreg", ev(F_WREG, 2'b00, 2'b00, 3'd0, 3'd4));
    step(); chk("add2_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // MOVR rd=1, rm=6, shift=11
    issue(OP_MOVR, 3'd1, 3'd0, 3'd6, 2'b11);
    step(); bus.start = 1'b0;
    chk("movr_ldb", ev(F_LDB, 2'b00, 2'b00, 3'd6, 3'd0));
    step(); chk("movr_exec", ev(F_EXR, 2'b11, ALU_ADD, 3'd0, 3'd0));
    step(); chk("movr_wreg", ev(F_WREG, 2'b00, 2'b00, 3'd0, 3'd1));
    step(); chk("movr_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // MVN rd=0, rm=3, then AND issued the cycle after done
    issue(OP_MVN, 3'd0, 3'd0, 3'd3, 2'b00);
    step(); bus.start = 1'b0;
    chk("mvn_ldb", ev(F_LDB, 2'b00, 2'b00, 3'd3, 3'd0));
    step(); chk("mvn_exec", ev(F_EXC, 2'b00, ALU_MVN, 3'd0, 3'd0));
    step(); chk("mvn_wreg", ev(F_WREG, 2'b00, 2'b00, 3'd0, 3'd0));
    step(); chk("mvn_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));

    // AND rd=7, rn=2, rm=3 aborted by reset in WREG
    issue(OP_AND, 3'd7, 3'd2, 3'd3, 2'b00);
    step(); bus.start = 1'b0;
    chk("and_lda", ev(F_LDA, 2'b00, 2'b00, 3'd2, 3'd0));
    step(); chk("and_ldb", ev(F_LDB, 2'b00, 2'b00, 3'd3, 3'd0));
    step(); chk("and_exec", ev(F_EXC, 2'b00, ALU_AND, 3'd0, 3'd0));
    step();
    chk_state("and_in_wreg", S_WREG);
    reset = 1'b1;
    #1;
    chk("and_wreg_reset_no_write", ev(F_DONE, 2'b00, 2'b00, 3'd0, 3'd7));
    step();
    reset = 1'b0;
    #1;
    chk("post_abort_ready", ev(F_IDLE, 2'b00, 2'b00, 3'd0, 3'd0));
    chk_state("post_abort_state", S_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
